// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one downstream bus host port among NrHosts requesters.
// Accepted host IDs are queued so in-order responses are routed back to their issuer.
module bus_host_arbiter #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NrHosts-1:0]                        host_req_i,
  output logic [NrHosts-1:0]                        host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]      host_addr_i,
  input  logic [NrHosts-1:0]                        host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]       host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]         host_wdata_i,
  output logic [NrHosts-1:0]                        host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]         host_rdata_o,
  output logic [NrHosts-1:0]                        host_err_o,
  output logic                                      bus_req_o,
  input  logic                                      bus_gnt_i,
  output logic [AddressWidth-1:0]                   bus_addr_o,
  output logic                                      bus_we_o,
  output logic [DataWidth/8-1:0]                    bus_be_o,
  output logic [DataWidth-1:0]                      bus_wdata_o,
  input  logic                                      bus_rvalid_i,
  input  logic [DataWidth-1:0]                      bus_rdata_i,
  input  logic                                      bus_err_i,
  output logic                                      unexpected_rsp_o
);

  localparam int unsigned IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdW-1:0]                      r_rr;
  logic [MaxOutstanding-1:0][IdW-1:0]  r_fifo;
  logic [PtrW-1:0]                     r_wptr;
  logic [PtrW-1:0]                     r_rptr;
  logic [CntW-1:0]                     r_count;
  logic                                r_unexpected;

  logic                                w_found;
  logic [IdW-1:0]                      w_winner;
  int unsigned                         w_idx;
  logic                                w_pop;
  logic                                w_push;
  logic                                w_can_issue;
  logic [IdW-1:0]                      w_head;

  // First requester at or after the round-robin pointer, searching upward.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      w_idx = (32'(r_rr) + i) % NrHosts;
      if (!w_found && host_req_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IdW'(w_idx);
      end
    end
  end

  assign w_head      = r_fifo[r_rptr];
  assign w_pop       = bus_rvalid_i && (r_count != '0);
  // A response popping this cycle frees a slot for a same-cycle issue.
  assign w_can_issue = (r_count < CntW'(MaxOutstanding)) || w_pop;
  assign bus_req_o   = w_found && w_can_issue;
  assign w_push      = bus_req_o && bus_gnt_i;

  always_comb begin
    bus_addr_o  = '0;
    bus_we_o    = 1'b0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    if (w_found) begin
      bus_addr_o  = host_addr_i[w_winner];
      bus_we_o    = host_we_i[w_winner];
      bus_be_o    = host_be_i[w_winner];
      bus_wdata_o = host_wdata_i[w_winner];
    end
  end

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    if (w_push) begin
      host_gnt_o[w_winner] = 1'b1;
    end
    if (w_pop) begin
      host_rvalid_o[w_head] = 1'b1;
      host_err_o[w_head]    = bus_err_i;
    end
  end

  assign host_rdata_o     = {NrHosts{bus_rdata_i}};
  assign unexpected_rsp_o = r_unexpected;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr         <= '0;
      r_fifo       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_unexpected <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_winner;
        r_wptr         <= (r_wptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_wptr + PtrW'(1);
        r_rr           <= (w_winner == IdW'(NrHosts - 1)) ? '0 : w_winner + IdW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_rptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
      if (bus_rvalid_i && (r_count == '0)) begin
        r_unexpected <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed table-driven bench for bus_host_arbiter (2 hosts, 2 outstanding).
module tb_bus_host_arbiter;

  logic              clk_i;
  logic              rst_ni;
  logic [1:0]        host_req_i;
  logic [1:0]        host_gnt_o;
  logic [1:0][31:0]  host_addr_i;
  logic [1:0]        host_we_i;
  logic [1:0][3:0]   host_be_i;
  logic [1:0][31:0]  host_wdata_i;
  logic [1:0]        host_rvalid_o;
  logic [1:0][31:0]  host_rdata_o;
  logic [1:0]        host_err_o;
  logic              bus_req_o;
  logic              bus_gnt_i;
  logic [31:0]       bus_addr_o;
  logic              bus_we_o;
  logic [3:0]        bus_be_o;
  logic [31:0]       bus_wdata_o;
  logic              bus_rvalid_i;
  logic [31:0]       bus_rdata_i;
  logic              bus_err_i;
  logic              unexpected_rsp_o;

  int n_checks = 0;
  int n_errors = 0;

  bus_host_arbiter #(
    .NrHosts        (2),
    .DataWidth      (32),
    .AddressWidth   (32),
    .MaxOutstanding (2)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .host_req_i       (host_req_i),
    .host_gnt_o       (host_gnt_o),
    .host_addr_i      (host_addr_i),
    .host_we_i        (host_we_i),
    .host_be_i        (host_be_i),
    .host_wdata_i     (host_wdata_i),
    .host_rvalid_o    (host_rvalid_o),
    .host_rdata_o     (host_rdata_o),
    .host_err_o       (host_err_o),
    .bus_req_o        (bus_req_o),
    .bus_gnt_i        (bus_gnt_i),
    .bus_addr_o       (bus_addr_o),
    .bus_we_o         (bus_we_o),
    .bus_be_o         (bus_be_o),
    .bus_wdata_o      (bus_wdata_o),
    .bus_rvalid_i     (bus_rvalid_i),
    .bus_rdata_i      (bus_rdata_i),
    .bus_err_i        (bus_err_i),
    .unexpected_rsp_o (unexpected_rsp_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
    logic        e_breq;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic [1:0]  e_err;
    logic [31:0] e_addr;
    logic        e_we;
    logic        e_unexp;
  } vec_t;

  localparam int NVec = 20;
  vec_t vecs[NVec];

  function automatic vec_t mk(logic [1:0] req, logic gnt, logic rv, logic err,
                              logic [31:0] rdata, logic e_breq, logic [1:0] e_gnt,
                              logic [1:0] e_rv, logic [1:0] e_err, logic [31:0] e_addr,
                              logic e_we, logic e_unexp);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.err = err; v.rdata = rdata;
    v.e_breq = e_breq; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_err = e_err;
    v.e_addr = e_addr; v.e_we = e_we; v.e_unexp = e_unexp;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic err, input logic [31:0] rdata);
    host_req_i   = req;
    bus_gnt_i    = gnt;
    bus_rvalid_i = rv;
    bus_err_i    = err;
    bus_rdata_i  = rdata;
  endtask

  function automatic logic [31:0] wdata_for(logic [31:0] addr);
    if (addr == 32'h0010_0000) return 32'hA5A5_A5A5;
    if (addr == 32'h0003_0000) return 32'h1234_5678;
    return 32'h0;
  endfunction

  initial begin
    rst_ni          = 1'b0;
    host_addr_i[0]  = 32'h0010_0000;
    host_addr_i[1]  = 32'h0003_0000;
    host_we_i       = 2'b10;
    host_be_i[0]    = 4'hF;
    host_be_i[1]    = 4'hF;
    host_wdata_i[0] = 32'hA5A5_A5A5;
    host_wdata_i[1] = 32'h1234_5678;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);

    //          req    gnt   rv    err   rdata          breq  gnt    rv     err    addr           we    unexp
    vecs[0]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0);
    vecs[1]  = mk(2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'b01, 2'b00, 2'b00, 32'h0010_0000, 1'b0, 1'b0);
    vecs[2]  = mk(2'b00, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF,  1'b0, 2'b00, 2'b01, 2'b00, 32'h0,         1'b0, 1'b0);
    vecs[3]  = mk(2'b11, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'b10, 2'b00, 2'b00, 32'h0003_0000, 1'b1, 1'b0);
    vecs[4]  = mk(2'b11, 1'b1, 1'b1, 1'b0, 32'h1111_1111, 1'b1, 2'b01, 2'b10, 2'b00, 32'h0010_0000, 1'b0, 1'b0);
    vecs[5]  = mk(2'b11, 1'b1, 1'b1, 1'b0, 32'h2222_2222, 1'b1, 2'b10, 2'b01, 2'b00, 32'h0003_0000, 1'b1, 1'b0);
    vecs[6]  = mk(2'b11, 1'b1, 1'b1, 1'b0, 32'h3333_3333, 1'b1, 2'b01, 2'b10, 2'b00, 32'h0010_0000, 1'b0, 1'b0);
    vecs[7]  = mk(2'b00, 1'b0, 1'b1, 1'b0, 32'h4444_4444, 1'b0, 2'b00, 2'b01, 2'b00, 32'h0,         1'b0, 1'b0);
    vecs[8]  = mk(2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'b01, 2'b00, 2'b00, 32'h0010_0000, 1'b0, 1'b0);
    vecs[9]  = mk(2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'b01, 2'b00, 2'b00, 32'h0010_0000, 1'b0, 1'b0);
    vecs[10] = mk(2'b01, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00, 2'b00, 32'h0010_0000, 1'b0, 1'b0);
    vecs[11] = mk(2'b01, 1'b1, 1'b1, 1'b0, 32'h5555_5555, 1'b1, 2'b01, 2'b01, 2'b00, 32'h0010_0000, 1'b0, 1'b0);
    vecs[12] = mk(2'b00, 1'b0, 1'b1, 1'b0, 32'h6666_6666, 1'b0, 2'b00, 2'b01, 2'b00, 32'h0,         1'b0, 1'b0);
    vecs[13] = mk(2'b00, 1'b0, 1'b1, 1'b1, 32'h7777_7777, 1'b0, 2'b00, 2'b01, 2'b01, 32'h0,         1'b0, 1'b0);
    vecs[14] = mk(2'b10, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 2'b10, 2'b00, 2'b00, 32'h0003_0000, 1'b1, 1'b0);
    vecs[15] = mk(2'b00, 1'b0, 1'b1, 1'b1, 32'h8888_8888, 1'b0, 2'b00, 2'b10, 2'b10, 32'h0,         1'b0, 1'b0);
    vecs[16] = mk(2'b00, 1'b0, 1'b1, 1'b0, 32'h9999_9999, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0);
    vecs[17] = mk(2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b1);
    vecs[18] = mk(2'b01, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 2'b00, 2'b00, 2'b00, 32'h0010_0000, 1'b0, 1'b1);
    vecs[19] = mk(2'b11, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 2'b00, 2'b00, 2'b00, 32'h0010_0000, 1'b0, 1'b1);

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst bus_req", 64'(bus_req_o), 64'h0);
    check("rst host_gnt", 64'(host_gnt_o), 64'h0);
    check("rst host_rvalid", 64'(host_rvalid_o), 64'h0);
    check("rst host_err", 64'(host_err_o), 64'h0);
    check("rst bus_addr", 64'(bus_addr_o), 64'h0);
    check("rst unexpected", 64'(unexpected_rsp_o), 64'h0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].err, vecs[i].rdata);
      @(negedge clk_i);
      check($sformatf("v%0d bus_req", i), 64'(bus_req_o), 64'(vecs[i].e_breq));
      check($sformatf("v%0d host_gnt", i), 64'(host_gnt_o), 64'(vecs[i].e_gnt));
      check($sformatf("v%0d host_rvalid", i), 64'(host_rvalid_o), 64'(vecs[i].e_rv));
      check($sformatf("v%0d host_err", i), 64'(host_err_o), 64'(vecs[i].e_err));
      check($sformatf("v%0d bus_addr", i), 64'(bus_addr_o), 64'(vecs[i].e_addr));
      check($sformatf("v%0d bus_we", i), 64'(bus_we_o), 64'(vecs[i].e_we));
      check($sformatf("v%0d bus_wdata", i), 64'(bus_wdata_o), 64'(wdata_for(vecs[i].e_addr)));
      check($sformatf("v%0d bus_be", i), 64'(bus_be_o),
            (vecs[i].e_addr != 32'h0) ? 64'hF : 64'h0);
      check($sformatf("v%0d rdata0", i), 64'(host_rdata_o[0]), 64'(vecs[i].rdata));
      check($sformatf("v%0d rdata1", i), 64'(host_rdata_o[1]), 64'(vecs[i].rdata));
      check($sformatf("v%0d unexpected", i), 64'(unexpected_rsp_o), 64'(vecs[i].e_unexp));
      @(posedge clk_i);
      #1;
    end

    // Reset mid-flight: host0 granted (pointer moves to 1), then reset.
    drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("mf grant", 64'(host_gnt_o), 64'h1);
    @(posedge clk_i);
    #1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("mf rst unexpected", 64'(unexpected_rsp_o), 64'h0);
    check("mf rst bus_req", 64'(bus_req_o), 64'h0);
    check("mf rst host_gnt", 64'(host_gnt_o), 64'h0);
    check("mf rst host_rvalid", 64'(host_rvalid_o), 64'h0);
    check("mf rst bus_addr", 64'(bus_addr_o), 64'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("mf rr zero addr", 64'(bus_addr_o), 64'h0010_0000);
    check("mf rr zero req", 64'(bus_req_o), 64'h1);
    check("mf no gnt", 64'(host_gnt_o), 64'h0);
    @(posedge clk_i);
    #1;
    drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
    @(negedge clk_i);
    check("mf late rvalid", 64'(host_rvalid_o), 64'h0);
    check("mf late unexp pre", 64'(unexpected_rsp_o), 64'h0);
    @(posedge clk_i);
    #1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    check("mf late unexp", 64'(unexpected_rsp_o), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
